uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two byte-stream requesters: port 0 is the core-side console, port 1 is the debug/trace source.
- Arbitrates round-robin at byte granularity.
- Acts as a bus master on the UART peripheral register port. For each byte it writes TX_DATA_BUF, polls CTRL until TI=1, then clears TI without disturbing RI.
- Sits between the requesters and the SoC register-bus mux in front of the uart peripheral.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshakes and UART register-port signals shared by the TX arbiter.
// The master modport is the arbiter side; the slave modport is the requesters plus UART.
interface uart_tx_arbiter_if;
    logic        s0_valid_i;
    logic [7:0]  s0_data_i;
    logic        s0_ready_o;
    logic        s1_valid_i;
    logic [7:0]  s1_data_i;
    logic        s1_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [31:0] rd_addr_o;
    logic [31:0] rd_data_i;

    modport master (
        input  s0_valid_i, s0_data_i, s1_valid_i, s1_data_i, rd_data_i,
        output s0_ready_o, s1_ready_o, wr_en_o, wr_addr_o, wr_data_o, rd_addr_o
    );

    modport slave (
        output s0_valid_i, s0_data_i, s1_valid_i, s1_data_i, rd_data_i,
        input  s0_ready_o, s1_ready_o, wr_en_o, wr_addr_o, wr_data_o, rd_addr_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter sharing one UART transmitter between console (s0) and trace (s1).
// Per byte: write TX_DATA_BUF, poll CTRL for TI, then clear TI while preserving RI.
//
// state   | meaning
// IDLE    | arbitrate; pulse ready and latch the byte of the winner
// WR_TX   | write latched byte to TX_DATA_BUF
// WAIT_TI | poll CTRL until TI, or give up at the timeout
// CLR_TI  | write CTRL back with TI cleared, count the byte
module uart_tx_arbiter #(
    parameter logic [31:0]     UART_BASE   = 32'h3000_0000,
    parameter int              TO_W        = 20,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd40000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_tx_arbiter_if.master    bus,
    output logic                 busy_o,
    output logic                 grant_o,
    output logic                 timeout_o,
    output logic [15:0]          tx_cnt_o
);
    localparam logic [31:0]     ADDR_CTRL = UART_BASE;
    localparam logic [31:0]     ADDR_TXD  = UART_BASE + 32'h4;
    localparam logic [TO_W-1:0] TO_LAST   = TIMEOUT_CYC - 1'b1;

    typedef enum logic [1:0] {IDLE, WR_TX, WAIT_TI, CLR_TI} state_t;

    state_t          state, state_nxt;
    logic            last_grant;
    logic            grant_q;
    logic [7:0]      byte_q;
    logic [TO_W-1:0] to_cnt;
    logic [15:0]     tx_cnt;
    logic            take0, take1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            byte_q     <= 8'h00;
            to_cnt     <= '0;
            tx_cnt     <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (take0) begin
                byte_q     <= bus.s0_data_i;
                last_grant <= 1'b0;
                grant_q    <= 1'b0;
            end else if (take1) begin
                byte_q     <= bus.s1_data_i;
                last_grant <= 1'b1;
                grant_q    <= 1'b1;
            end
            if (state == WR_TX) begin
                to_cnt <= '0;
            end else if (state == WAIT_TI) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state == CLR_TI) begin
                tx_cnt <= tx_cnt + 16'h0001;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        take0         = 1'b0;
        take1         = 1'b0;
        bus.wr_en_o   = 1'b0;
        bus.wr_addr_o = 32'h0;
        bus.wr_data_o = 32'h0;
        timeout_o     = 1'b0;
        case (state)
            IDLE: begin
                // last_grant==1 means s1 was served last, so s0 wins a tie
                if (bus.s0_valid_i && (!bus.s1_valid_i || last_grant)) begin
                    take0 = 1'b1;
                end else if (bus.s1_valid_i) begin
                    take1 = 1'b1;
                end
                if (take0 || take1) begin
                    state_nxt = WR_TX;
                end
            end
            WR_TX: begin
                bus.wr_en_o   = 1'b1;
                bus.wr_addr_o = ADDR_TXD;
                bus.wr_data_o = {24'h0, byte_q};
                state_nxt     = WAIT_TI;
            end
            WAIT_TI: begin
                // rd_data_i lags one edge, so the entry cycle still shows pre-write CTRL
                if ((to_cnt != '0) && bus.rd_data_i[1]) begin
                    state_nxt = CLR_TI;
                end else if (to_cnt == TO_LAST) begin
                    timeout_o = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CLR_TI: begin
                // must follow TI immediately so the written-back RI is current
                bus.wr_en_o   = 1'b1;
                bus.wr_addr_o = ADDR_CTRL;
                bus.wr_data_o = {bus.rd_data_i[31:2], 1'b0, bus.rd_data_i[0]};
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.s0_ready_o = take0;
    assign bus.s1_ready_o = take1;
    assign bus.rd_addr_o  = ADDR_CTRL;
    assign busy_o         = (state != IDLE);
    assign grant_o        = grant_q;
    assign tx_cnt_o       = tx_cnt;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART that raises TI 50 cycles
// after each TX_DATA_BUF write; timeout shortened to 200 cycles.
module tb_uart_tx_arbiter;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, grant, timeout;
    logic [15:0] tx_cnt;

    uart_tx_arbiter_if bus_if ();

    uart_tx_arbiter #(
        .UART_BASE   (BASE),
        .TO_W        (20),
        .TIMEOUT_CYC (20'd200)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .busy_o    (busy),
        .grant_o   (grant),
        .timeout_o (timeout),
        .tx_cnt_o  (tx_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // UART model state
    logic [31:0] ctrl = 32'h0;
    int          ti_timer = 0;
    bit          ti_en = 1'b1;
    bit          ri_mode = 1'b0;
    bit          m_clear = 1'b0;
    logic [7:0]  tx_log[$];
    int          n_ctrl_wr = 0;
    int          n_bad_addr = 0;
    logic [31:0] last_ctrl_wr = 32'h0;

    // monitor state
    int          cyc = 0;
    bit          gnt_log[$];
    int          n_acc0 = 0, n_acc1 = 0;
    int          n_to = 0, to_cyc = 0, wr_cyc = 0;
    int          n_idle_bad = 0, n_both = 0;

    always @(posedge clk) begin : uart_model
        logic [31:0] c;
        c = ctrl;
        if (m_clear) c = 32'h0;
        if (bus_if.wr_en_o) begin
            if (bus_if.wr_addr_o == BASE) begin
                c = bus_if.wr_data_o;
                n_ctrl_wr++;
                last_ctrl_wr = bus_if.wr_data_o;
            end else if (bus_if.wr_addr_o != BASE + 32'h4) begin
                n_bad_addr++;
            end
        end
        if (bus_if.wr_en_o && bus_if.wr_addr_o == BASE + 32'h4) begin
            tx_log.push_back(bus_if.wr_data_o[7:0]);
            ti_timer = 50;
        end else if (ti_timer > 0) begin
            ti_timer--;
            if (ti_timer == 0 && ti_en) begin
                c[1] = 1'b1;
                if (ri_mode) c[0] = 1'b1;
            end
        end
        bus_if.rd_data_i <= ctrl;
        ctrl <= c;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_if.s0_ready_o) begin gnt_log.push_back(1'b0); n_acc0++; end
        if (bus_if.s1_ready_o) begin gnt_log.push_back(1'b1); n_acc1++; end
        if (bus_if.s0_ready_o && bus_if.s1_ready_o) n_both++;
        if (timeout) begin n_to++; to_cyc = cyc; end
        if (bus_if.wr_en_o && bus_if.wr_addr_o == BASE + 32'h4) wr_cyc = cyc;
        if (!bus_if.wr_en_o && (bus_if.wr_addr_o != 32'h0 || bus_if.wr_data_o != 32'h0)) n_idle_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input bit port, input logic [7:0] d, input string tag);
        int n = 0;
        int a0 = n_acc0;
        int a1 = n_acc1;
        if (port) begin bus_if.s1_data_i = d; bus_if.s1_valid_i = 1'b1; end
        else      begin bus_if.s0_data_i = d; bus_if.s0_valid_i = 1'b1; end
        while ((port ? (n_acc1 == a1) : (n_acc0 == a0)) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        bus_if.s0_valid_i = 1'b0;
        bus_if.s1_valid_i = 1'b0;
        check({tag, "_acc"}, port ? (n_acc1 - a1) : (n_acc0 - a0), 1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy && n < 400) begin @(posedge clk); #1; n++; end
        check({tag, "_done"}, busy, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [63:0] p;
        int w0, c0, t0;
        bus_if.s0_valid_i = 1'b0;
        bus_if.s1_valid_i = 1'b0;
        bus_if.s0_data_i  = 8'h00;
        bus_if.s1_data_i  = 8'h00;

        // reset values
        #12;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_timeout", timeout, 0);
        check("rst_txcnt", tx_cnt, 0);
        check("rst_wren", bus_if.wr_en_o, 0);
        check("rst_rdaddr", bus_if.rd_addr_o, BASE);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // single byte from s0; data changed after grant must not matter
        bus_if.s0_data_i = 8'hA5; bus_if.s0_valid_i = 1'b1; #1;
        check("t1_ready0", bus_if.s0_ready_o, 1);
        check("t1_ready1", bus_if.s1_ready_o, 0);
        @(posedge clk); #1;
        bus_if.s0_valid_i = 1'b0; bus_if.s0_data_i = 8'hFF; #1;
        check("t1_wren", bus_if.wr_en_o, 1);
        check("t1_wraddr", bus_if.wr_addr_o, 32'h3000_0004);
        check("t1_wrdata", bus_if.wr_data_o, 32'h0000_00A5);
        check("t1_busy", busy, 1);
        check("t1_ready_pulse", bus_if.s0_ready_o, 0);
        wait_done("t1");
        check("t1_txlog", tx_log.size(), 1);
        check("t1_ctrl_wr_n", n_ctrl_wr, 1);
        check("t1_ctrl_wr_data", last_ctrl_wr, 32'h0);
        check("t1_txcnt", tx_cnt, 1);

        // both requesters hold valid, 4 bytes each, starting from reset
        do_reset();
        gnt_log.delete(); tx_log.delete();
        n_acc0 = 0; n_acc1 = 0;
        bus_if.s0_data_i = 8'h11; bus_if.s1_data_i = 8'h22;
        bus_if.s0_valid_i = 1'b1; bus_if.s1_valid_i = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (n_acc0 >= 4) bus_if.s0_valid_i = 1'b0;
            if (n_acc1 >= 4) bus_if.s1_valid_i = 1'b0;
            if (n_acc0 >= 4 && n_acc1 >= 4 && !busy) break;
        end
        bus_if.s0_valid_i = 1'b0; bus_if.s1_valid_i = 1'b0;
        check("t2_ngrants", gnt_log.size(), 8);
        p = 64'h0;
        for (int i = 0; i < 8; i++) p = {p[55:0], 7'h0, gnt_log[i]};
        check("t2_grant_order", p, 64'h0001_0001_0001_0001 << 0 | 64'h0);
        p = 64'h0;
        for (int i = 0; i < 8; i++) p = {p[55:0], tx_log[i]};
        check("t2_bytes", p, 64'h1122_1122_1122_1122);
        check("t2_txcnt", tx_cnt, 8);

        // RI set together with TI must survive the CTRL write-back
        ri_mode = 1'b1;
        accept(1'b1, 8'h5A, "t3");
        check("t3_grant", grant, 1);
        wait_done("t3");
        check("t3_ctrl_wr_data", last_ctrl_wr, 32'h1);
        check("t3_ri_kept", ctrl[0], 1);
        check("t3_ti_clr", ctrl[1], 0);
        check("t3_txcnt", tx_cnt, 9);
        ri_mode = 1'b0;
        m_clear = 1'b1; @(posedge clk); #1 m_clear = 1'b0;

        // TI never arrives: single timeout pulse, no CTRL write, count unchanged
        ti_en = 1'b0;
        t0 = n_to; c0 = n_ctrl_wr;
        accept(1'b0, 8'h77, "t4");
        wait_done("t4");
        check("t4_to_pulses", n_to - t0, 1);
        check("t4_to_delay", to_cyc - wr_cyc, 200);
        check("t4_no_ctrl_wr", n_ctrl_wr - c0, 0);
        check("t4_txcnt", tx_cnt, 9);
        check("t4_byte", tx_log[tx_log.size()-1], 8'h77);
        ti_en = 1'b1;
        accept(1'b1, 8'h88, "t4b");
        wait_done("t4b");
        check("t4b_txcnt", tx_cnt, 10);
        check("t4b_to_pulses", n_to - t0, 1);

        // asynchronous reset while waiting for TI
        accept(1'b1, 8'h33, "t5");
        repeat (10) begin @(posedge clk); #1; end
        check("t5_busy_pre", busy, 1);
        check("t5_grant_pre", grant, 1);
        #3 rst_n = 1'b0; #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_grant", grant, 0);
        check("t5_rst_txcnt", tx_cnt, 0);
        check("t5_rst_wren", bus_if.wr_en_o, 0);
        check("t5_rst_timeout", timeout, 0);
        w0 = tx_log.size(); c0 = n_ctrl_wr;
        repeat (60) @(posedge clk);
        check("t5_no_writes", (tx_log.size() - w0) + (n_ctrl_wr - c0), 0);
        #1 m_clear = 1'b1; @(posedge clk); #1 m_clear = 1'b0; rst_n = 1'b1;
        gnt_log.delete();
        n_acc0 = 0; n_acc1 = 0;
        bus_if.s0_data_i = 8'h44; bus_if.s1_data_i = 8'h55;
        bus_if.s0_valid_i = 1'b1; bus_if.s1_valid_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (n_acc0 >= 1) bus_if.s0_valid_i = 1'b0;
            if (n_acc1 >= 1) bus_if.s1_valid_i = 1'b0;
            if (n_acc0 >= 1 && n_acc1 >= 1 && !busy) break;
        end
        bus_if.s0_valid_i = 1'b0; bus_if.s1_valid_i = 1'b0;
        check("t5_first_grant", gnt_log[0], 0);
        check("t5_second_grant", gnt_log[1], 1);
        check("t5_bytes", {tx_log[tx_log.size()-2], tx_log[tx_log.size()-1]}, 16'h4455);
        check("t5_txcnt", tx_cnt, 2);

        // tx_cnt wrap
        force dut.tx_cnt = 16'hFFFF;
        @(posedge clk); #1;
        release dut.tx_cnt;
        accept(1'b0, 8'h99, "t6");
        wait_done("t6");
        check("t6_wrap", tx_cnt, 0);

        check("bus_idle_zero", n_idle_bad, 0);
        check("bad_addr", n_bad_addr, 0);
        check("dual_ready", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
